qc_ldpc_iter_ctrl: RTL

Iteration controller and syndrome checker for the parametrised quasi-cyclic LDPC decoder (R block-columns, C block-rows, circulant size D). It holds a runtime-programmable circulant shift table, in which any block may be a zero block. It launches decoder iterations and evaluates the parity syndrome of each iteration's hard decisions, one block-row per cycle. Decoding terminates early on a zero syndrome or at a programmable iteration limit. It sits beside the CNU/VNU arrays and the cyclic-shift fabric, and drives their iteration start.

---
 rtl/qc_ldpc_iter_ctrl_pkg.sv | 21 ++
 rtl/qc_ldpc_iter_ctrl_if.sv | 36 +++
 rtl/qc_ldpc_iter_ctrl_row_syndrome.sv | 23 ++
 rtl/qc_ldpc_iter_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/qc_ldpc_iter_ctrl_pkg.sv
// Shared types for the QC-LDPC iteration controller: code dimensions, FSM states, shift-table entry.
// Pure declarations; no logic, no latency.
package ldpc_pkg;
   localparam int R_DEF      = 5;
   localparam int C_DEF      = 3;
   localparam int D_DEF      = 8;
   localparam int ITER_W_DEF = 6;
   localparam int SHIFT_W    = $clog2(D_DEF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic               en;
      logic [SHIFT_W-1:0] shift;
   } shift_ent_t;
endpackage

// File: rtl/qc_ldpc_iter_ctrl_if.sv
// Config, control and decision bus between the iteration controller and its decoder datapath.
// Plain wires; no latency, no flow control beyond the start/iter_go/dec_valid protocol.
interface qc_ldpc_iter_ctrl_if import ldpc_pkg::*; #(
   parameter int R      = R_DEF,
   parameter int C      = C_DEF,
   parameter int D      = D_DEF,
   parameter int ITER_W = ITER_W_DEF
);
   localparam int AW = $clog2(C*R);
   localparam int SW = $clog2(D);

   logic              cfg_we;
   logic [AW-1:0]     cfg_addr;
   logic [SW-1:0]     cfg_shift;
   logic              cfg_en;
   logic              start;
   logic [ITER_W-1:0] max_iter;
   logic              iter_go;
   logic              dec_valid;
   logic [R*D-1:0]    dec_in;
   logic              busy;
   logic              done;
   logic              success;
   logic [ITER_W-1:0] iter_cnt;
   logic [R*D-1:0]    dec_out;

   modport master (
      output cfg_we, cfg_addr, cfg_shift, cfg_en, start, max_iter, dec_valid, dec_in,
      input  iter_go, busy, done, success, iter_cnt, dec_out
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_shift, cfg_en, start, max_iter, dec_valid, dec_in,
      output iter_go, busy, done, success, iter_cnt, dec_out
   );
endinterface

// File: rtl/qc_ldpc_iter_ctrl_row_syndrome.sv
// D parity checks of one block-row: XOR of every enabled block-column rotated by its circulant shift.
// Purely combinational; no backpressure.
module qc_row_syndrome import ldpc_pkg::*; #(
   parameter int R = R_DEF,
   parameter int D = D_DEF
) (
   input  shift_ent_t       ent_i [R],
   input  logic [R*D-1:0]   dec_i,
   output logic [D-1:0]     syn_o
);
   logic [D-1:0] blk;

   always_comb begin
      syn_o = '0;
      blk   = '0;
      for (int j = 0; j < R; j++) begin
         blk = dec_i[j*D +: D];
         // Rotate right so bit k picks variable (k + shift) mod D; a zero shift leaves blk as is.
         if (ent_i[j].en)
            syn_o = syn_o ^ ((blk >> ent_i[j].shift) | (blk << (D - int'(ent_i[j].shift))));
      end
   end
endmodule

// File: rtl/qc_ldpc_iter_ctrl.sv
// QC-LDPC iteration controller: launches iterations, checks the syndrome one block-row per cycle.
// C+1 cycles from dec_valid to done or the next iter_go; start and table writes are ignored while busy.
module qc_ldpc_iter_ctrl import ldpc_pkg::*; #(
   parameter int R      = R_DEF,
   parameter int C      = C_DEF,
   parameter int D      = D_DEF,
   parameter int ITER_W = ITER_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   qc_ldpc_iter_ctrl_if.slave bus
);
   localparam int AW = $clog2(C*R);
   localparam int RW = (C > 1) ? $clog2(C) : 1;

   state_e            state_q, state_d;
   shift_ent_t        tbl_q [C][R];
   shift_ent_t        row_ent [R];
   logic [ITER_W-1:0] lim_q, lim_d, cnt_q, cnt_d;
   logic [RW-1:0]     row_q, row_d;
   logic [R*D-1:0]    dec_q, dec_d;
   logic              nz_q, nz_d, succ_q, succ_d;
   logic              go_q, go_d, done_q, done_d;
   logic [D-1:0]      row_syn;
   logic [SHIFT_W:0]  shift_mod;
   logic              idle_like, last_row, nz_final;

   assign idle_like = (state_q == IDLE) || (state_q == DONE);
   assign last_row  = (row_q == RW'(C-1));
   assign nz_final  = nz_q | (|row_syn);
   // One extra bit keeps the modulus representable when D is a power of two.
   assign shift_mod = {1'b0, bus.cfg_shift} % (SHIFT_W+1)'(D);

   always_comb begin
      for (int j = 0; j < R; j++) row_ent[j] = tbl_q[row_q][j];
   end

   qc_row_syndrome #(.R(R), .D(D)) u_row (
      .ent_i (row_ent),
      .dec_i (dec_q),
      .syn_o (row_syn)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < C; i++)
            for (int j = 0; j < R; j++)
               tbl_q[i][j] <= '{en: 1'b1, shift: '0};
      end else if (bus.cfg_we && idle_like) begin
         for (int i = 0; i < C; i++)
            for (int j = 0; j < R; j++)
               if (bus.cfg_addr == AW'(i*R + j))
                  tbl_q[i][j] <= '{en: bus.cfg_en, shift: shift_mod[SHIFT_W-1:0]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (bus.start) state_d = ITER;
         ITER:       if (bus.dec_valid) state_d = CHECK;
         CHECK:      if (last_row) state_d = (!nz_final || cnt_q == lim_q) ? DONE : ITER;
         default:    state_d = IDLE;
      endcase
      go_d   = (state_d == ITER) && (state_q != ITER);
      done_d = (state_d == DONE) && (state_q != DONE);
   end

   always_comb begin
      lim_d  = lim_q;
      cnt_d  = cnt_q;
      row_d  = row_q;
      dec_d  = dec_q;
      nz_d   = nz_q;
      succ_d = succ_q;
      if (bus.start && idle_like) begin
         lim_d  = (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
         cnt_d  = '0;
         succ_d = 1'b0;
      end
      if (state_q == ITER && bus.dec_valid) begin
         dec_d = bus.dec_in;
         cnt_d = cnt_q + ITER_W'(1);
         nz_d  = 1'b0;
         row_d = '0;
      end
      if (state_q == CHECK) begin
         nz_d  = nz_final;
         row_d = row_q + RW'(1);
         if (last_row && !nz_final) succ_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lim_q  <= '0;
         cnt_q  <= '0;
         row_q  <= '0;
         dec_q  <= '0;
         nz_q   <= 1'b0;
         succ_q <= 1'b0;
         go_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         lim_q  <= lim_d;
         cnt_q  <= cnt_d;
         row_q  <= row_d;
         dec_q  <= dec_d;
         nz_q   <= nz_d;
         succ_q <= succ_d;
         go_q   <= go_d;
         done_q <= done_d;
      end
   end

   always_comb begin
      bus.busy     = (state_q == ITER) || (state_q == CHECK);
      bus.iter_go  = go_q;
      bus.done     = done_q;
      bus.success  = succ_q;
      bus.iter_cnt = cnt_q;
      bus.dec_out  = dec_q;
   end
endmodule
